dwt_result_collector: RTL and testbench

- Sink end of the DWT core's ap_vld output interface.
- Captures each coefficient word the DWT core presents on data_out/data_out_ap_vld into an internal frame buffer.
- Once a frame completes, replays the buffer in order on a valid/ready stream toward the downstream consumer.
- Counterpart of the sample feeder that drives data/ap_start into the core. It decouples the core's bursty ap_vld writes from a back-pressured consumer.

---
 rtl/dwt_pkg.sv | 18 +
 rtl/dwt_result_collector_if.sv | 13 +
 rtl/dwt_coef_ram.sv | 25 ++
 rtl/dwt_result_collector.sv | 184 ++++++++++++++++++
 tb/tb_dwt_result_collector.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dwt_pkg.sv
// Shared constants and state encoding for the DWT result path.
package dwt_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 1024;
    localparam int ADDR_W    = 10;

    // Frame length expressed in frame counter width (ADDR_W+1 bits).
    localparam logic [ADDR_W:0] FRAME_FULL = (ADDR_W + 1)'(FRAME_LEN);

    // One-hot, same encoding style as the sample feeder FSM.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_CAPTURE = 3'b010,
        ST_DRAIN   = 3'b100
    } state_t;

endpackage

// File: rtl/dwt_result_collector_if.sv
// Readout stream from the collector to the downstream consumer.
interface dwt_result_collector_if;
    import dwt_pkg::*;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/dwt_coef_ram.sv
// Coefficient frame buffer: one write port, one synchronous read port.
module dwt_coef_ram
    import dwt_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Write and registered read; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dwt_result_collector.sv
// Collects DWT coefficient words into a frame buffer, then replays the
// frame on a valid/ready stream.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_IDLE    | waiting for arm; core writes are ignored
//  ST_CAPTURE | writing core words into the buffer until full or ap_done
//  ST_DRAIN   | reading the buffer out through the output skid
module dwt_result_collector
    import dwt_pkg::*;
(
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   arm,
    input  logic [DATA_W-1:0]      dwt_data,
    input  logic                   dwt_data_vld,
    input  logic                   dwt_done,
    dwt_result_collector_if.master m_axis,
    output logic                   busy,
    output logic [ADDR_W:0]        frame_cnt,
    output logic                   overflow,
    output logic                   drain_done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic              r_rd_all;
    logic              r_rd_pend;
    logic              r_rd_last_pend;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_last;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_m_last;
    logic              r_busy;
    logic [ADDR_W:0]   r_frame_cnt;
    logic              r_overflow;
    logic              r_drain_done;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_pop;
    logic              w_out_load;
    logic [1:0]        w_occ;
    logic              w_room;
    logic              w_rd_issue;
    logic              w_rd_issue_last;
    logic              w_full;

    assign w_full   = (r_frame_cnt == FRAME_FULL);
    assign w_wr_en  = (r_state == ST_CAPTURE) && dwt_data_vld && !w_full;

    // Output register plus skid entry plus one read in flight never exceed
    // two held words, so a read is issued only when a slot will be free.
    assign w_pop           = r_m_valid && m_axis.m_ready;
    assign w_out_load      = !r_m_valid || w_pop;
    assign w_occ           = 2'(r_m_valid) + 2'(r_skid_vld) + 2'(r_rd_pend);
    assign w_room          = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
    assign w_rd_issue      = (r_state == ST_DRAIN) && !r_rd_all && w_room;
    assign w_rd_issue_last = ({1'b0, r_rptr} == (r_frame_cnt - 1'b1));

    dwt_coef_ram u_ram (
        .i_clk     (ap_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr),
        .i_wr_data (dwt_data),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_ram_rdata)
    );

    // Collector FSM, pointers, counters and readout skid.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state        <= ST_IDLE;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_rd_all       <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_last_pend <= 1'b0;
            r_skid_data    <= '0;
            r_skid_last    <= 1'b0;
            r_skid_vld     <= 1'b0;
            r_m_data       <= '0;
            r_m_valid      <= 1'b0;
            r_m_last       <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_cnt    <= '0;
            r_overflow     <= 1'b0;
            r_drain_done   <= 1'b0;
        end else begin
            r_drain_done   <= 1'b0;
            r_rd_pend      <= w_rd_issue;
            r_rd_last_pend <= w_rd_issue && w_rd_issue_last;

            // Stop advancing after the final read so rptr never wraps.
            if (w_rd_issue) begin
                if (w_rd_issue_last) r_rd_all <= 1'b1;
                else                 r_rptr   <= r_rptr + 1'b1;
            end

            // Output register takes the skid first, then the RAM word.
            if (w_out_load) begin
                if (r_skid_vld) begin
                    r_m_data  <= r_skid_data;
                    r_m_last  <= r_skid_last;
                    r_m_valid <= 1'b1;
                end else if (r_rd_pend) begin
                    r_m_data  <= w_ram_rdata;
                    r_m_last  <= r_rd_last_pend;
                    r_m_valid <= 1'b1;
                end else begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end
            end

            if (r_skid_vld && w_out_load) begin
                r_skid_vld  <= r_rd_pend;
                r_skid_data <= w_ram_rdata;
                r_skid_last <= r_rd_last_pend;
            end else if (!r_skid_vld && !w_out_load && r_rd_pend) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= w_ram_rdata;
                r_skid_last <= r_rd_last_pend;
            end

            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state     <= ST_CAPTURE;
                        r_busy      <= 1'b1;
                        r_frame_cnt <= '0;
                        r_wptr      <= '0;
                        r_overflow  <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (dwt_data_vld) begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                            if (r_wptr != {ADDR_W{1'b1}}) r_wptr <= r_wptr + 1'b1;
                        end
                    end
                    // A word arriving with ap_done is counted, so it also
                    // makes an otherwise empty frame non-empty.
                    if (w_full || (dwt_done && ((r_frame_cnt != '0) || dwt_data_vld))) begin
                        r_state  <= ST_DRAIN;
                        r_rptr   <= '0;
                        r_rd_all <= 1'b0;
                    end else if (dwt_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (dwt_data_vld) r_overflow <= 1'b1;
                    if (w_pop && r_m_last) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_drain_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.m_data  = r_m_data;
    assign m_axis.m_valid = r_m_valid;
    assign m_axis.m_last  = r_m_last;
    assign busy           = r_busy;
    assign frame_cnt      = r_frame_cnt;
    assign overflow       = r_overflow;
    assign drain_done     = r_drain_done;

endmodule

// File: tb/tb_dwt_result_collector.sv
// Directed bench for the DWT result collector.
module tb_dwt_result_collector;
    import dwt_pkg::*;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              arm = 1'b0;
    logic [DATA_W-1:0] dwt_data = '0;
    logic              dwt_data_vld = 1'b0;
    logic              dwt_done = 1'b0;
    logic              busy;
    logic [ADDR_W:0]   frame_cnt;
    logic              overflow;
    logic              drain_done;

    int n_cmp = 0;
    int n_bad = 0;

    dwt_result_collector_if u_if ();

    dwt_result_collector dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .arm          (arm),
        .dwt_data     (dwt_data),
        .dwt_data_vld (dwt_data_vld),
        .dwt_done     (dwt_done),
        .m_axis       (u_if.master),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .overflow     (overflow),
        .drain_done   (drain_done)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm();
        @(negedge ap_clk) arm = 1'b1;
        @(negedge ap_clk) arm = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
    endtask

    task automatic send_words(input int n, input logic [31:0] base, input bit done_last);
        for (int i = 0; i < n; i++) begin
            @(negedge ap_clk);
            dwt_data_vld = 1'b1;
            dwt_data     = base + 32'(i);
            dwt_done     = done_last && (i == n - 1);
        end
        @(negedge ap_clk);
        dwt_data_vld = 1'b0;
        dwt_done     = 1'b0;
    endtask

    // mode 0: m_ready always high; mode 1: m_ready pattern 1,0,0,1.
    task automatic drain(input int n_read, input int total, input logic [31:0] base,
                         input int mode, input int max_cyc);
        int got = 0;
        int cyc = 0;
        int first_acc = -1;
        int last_acc = 0;
        bit held = 0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        logic rdy;
        while (got < n_read && cyc < max_cyc) begin
            if (held) begin
                check("stall_valid", 32'(u_if.m_valid), 32'd1);
                check("stall_data", u_if.m_data, hd);
                check("stall_last", 32'(u_if.m_last), 32'(hl));
            end
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            u_if.m_ready = rdy;
            if (u_if.m_valid && rdy) begin
                check("rd_data", u_if.m_data, base + 32'(got));
                check("rd_last", 32'(u_if.m_last), 32'(got == total - 1));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                got++;
                held = 0;
            end else if (u_if.m_valid) begin
                held = 1;
                hd = u_if.m_data;
                hl = u_if.m_last;
            end else begin
                held = 0;
            end
            cyc++;
            @(negedge ap_clk);
        end
        u_if.m_ready = 1'b0;
        check("drain_count", 32'(got), 32'(n_read));
        if (mode == 0) check("throughput", 32'(last_acc - first_acc), 32'(n_read - 1));
        if (n_read == total) begin
            check("drain_done_pulse", 32'(drain_done), 32'd1);
            check("valid_drop", 32'(u_if.m_valid), 32'd0);
            check("busy_drop", 32'(busy), 32'd0);
            @(negedge ap_clk);
            check("drain_done_clear", 32'(drain_done), 32'd0);
        end
    endtask

    initial begin
        int seen_valid;
        u_if.m_ready = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 32'(u_if.m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_done", 32'(drain_done), 32'd0);
        @(negedge ap_clk) ap_rst_n = 1'b1;

        // Stray words in IDLE are ignored
        send_words(3, 32'h77, 1'b0);
        check("idle_ovf", 32'(overflow), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cnt", 32'(frame_cnt), 32'd0);

        // Full frame, no back-pressure
        do_arm();
        send_words(FRAME_LEN, 32'd0, 1'b0);
        drain(FRAME_LEN, FRAME_LEN, 32'd0, 0, 3000);
        check("full_cnt", 32'(frame_cnt), 32'd1024);
        check("full_ovf", 32'(overflow), 32'd0);

        // Short frame ended by ap_done on the 5th word; first valid 2 cycles into DRAIN
        do_arm();
        send_words(5, 32'hA0, 1'b1);
        check("short_busy", 32'(busy), 32'd1);
        check("short_lat0", 32'(u_if.m_valid), 32'd0);
        @(negedge ap_clk);
        check("short_lat1", 32'(u_if.m_valid), 32'd0);
        @(negedge ap_clk);
        check("short_lat2", 32'(u_if.m_valid), 32'd1);
        drain(5, 5, 32'hA0, 0, 100);
        check("short_cnt", 32'(frame_cnt), 32'd5);

        // Back-pressure
        do_arm();
        send_words(FRAME_LEN, 32'h1000, 1'b0);
        drain(FRAME_LEN, FRAME_LEN, 32'h1000, 1, 5000);
        check("bp_cnt", 32'(frame_cnt), 32'd1024);

        // Overflow: two extra words are dropped
        do_arm();
        send_words(FRAME_LEN + 2, 32'd0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        drain(FRAME_LEN, FRAME_LEN, 32'd0, 0, 3000);
        check("ovf_cnt", 32'(frame_cnt), 32'd1024);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Empty frame
        do_arm();
        check("empty_ovf_clr", 32'(overflow), 32'd0);
        dwt_done = 1'b1;
        @(negedge ap_clk) dwt_done = 1'b0;
        check("empty_busy", 32'(busy), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (u_if.m_valid) seen_valid++;
            @(negedge ap_clk);
        end
        check("empty_novalid", 32'(seen_valid), 32'd0);
        check("empty_cnt", 32'(frame_cnt), 32'd0);
        check("empty_ovf", 32'(overflow), 32'd0);

        // Reset mid-drain, then a 4-word frame
        do_arm();
        send_words(FRAME_LEN, 32'h2000, 1'b0);
        drain(300, FRAME_LEN, 32'h2000, 0, 1000);
        check("pre_rst_valid", 32'(u_if.m_valid), 32'd1);
        #1 ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(u_if.m_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        do_arm();
        send_words(4, 32'h55, 1'b1);
        drain(4, 4, 32'h55, 0, 100);
        check("post_rst_cnt", 32'(frame_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
